// File: rtl/cv32e40p_tmr_recovery_ctrl.sv
// Recovery controller for the TMR majority voter: counts per-replica mismatches, stalls
// and resyncs a drifting replica, and escalates to a sticky fault. Option: CV32E40P_TMR_THRESHOLD_EN.
module cv32e40p_tmr_recovery_ctrl #(
    parameter int unsigned CNT_WIDTH      = 8,
    parameter int unsigned THRESHOLD      = 3,
    parameter int unsigned RESYNC_TIMEOUT = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 valid_i,
    input  logic                 err_a_i,
    input  logic                 err_b_i,
    input  logic                 err_c_i,
    output logic                 stall_o,
    output logic                 resync_req_o,
    output logic [1:0]           resync_sel_o,
    input  logic                 resync_ack_i,
    input  logic                 clear_i,
    output logic                 fault_o,
    output logic                 timeout_o,
    output logic [CNT_WIDTH-1:0] err_cnt_a_o,
    output logic [CNT_WIDTH-1:0] err_cnt_b_o,
    output logic [CNT_WIDTH-1:0] err_cnt_c_o
);

    localparam int unsigned     TMO_W    = $clog2(RESYNC_TIMEOUT + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(RESYNC_TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, STALL, RESYNC, FAULT} state_e;

    state_e           state_q, state_d;
    logic             stall_q, stall_d;
    logic             req_q, req_d;
    logic             fault_q, fault_d;
    logic             timeout_q, timeout_d;
    logic [1:0]       sel_q, sel_d;
    logic [TMO_W-1:0] tmo_q, tmo_d;

    logic [2:0] err_vec;
    logic       single_err;
    logic       multi_err;
    logic [1:0] err_idx;
    logic       thr_hit;
    logic       cnt_inc_en;
    logic       cnt_clr_all;
    logic       cnt_clr_sel;

    assign err_vec    = {err_c_i, err_b_i, err_a_i};
    assign single_err = (err_vec == 3'b001) || (err_vec == 3'b010) || (err_vec == 3'b100);
    assign multi_err  = (err_vec == 3'b011) || (err_vec == 3'b101) ||
                        (err_vec == 3'b110) || (err_vec == 3'b111);

    always_comb begin
        case (err_vec)
            3'b010:  err_idx = 2'd1;
            3'b100:  err_idx = 2'd2;
            default: err_idx = 2'd0;
        endcase
    end

    // NOTE: every signal driven here gets a default first so no path can infer a latch.
    always_comb begin
        state_d     = state_q;
        stall_d     = stall_q;
        req_d       = req_q;
        fault_d     = fault_q;
        timeout_d   = timeout_q;
        sel_d       = sel_q;
        tmo_d       = tmo_q;
        cnt_inc_en  = 1'b0;
        cnt_clr_all = 1'b0;
        cnt_clr_sel = 1'b0;

        unique case (state_q)
            IDLE: begin
                stall_d = 1'b0;
                req_d   = 1'b0;
                if (clear_i) begin
                    cnt_clr_all = 1'b1;
                end else if (valid_i && multi_err) begin
                    state_d = FAULT;
                    fault_d = 1'b1;
                    stall_d = 1'b1;
                end else if (valid_i && single_err) begin
                    cnt_inc_en = 1'b1;
                    if (thr_hit) begin
                        state_d = STALL;
                        stall_d = 1'b1;
                        sel_d   = err_idx;
                    end
                end
            end
            STALL: begin
                // One drain cycle, then the resync window opens with a fresh timeout count.
                state_d = RESYNC;
                stall_d = 1'b1;
                req_d   = 1'b1;
                tmo_d   = '0;
            end
            RESYNC: begin
                if (resync_ack_i) begin
                    state_d     = IDLE;
                    stall_d     = 1'b0;
                    req_d       = 1'b0;
                    cnt_clr_sel = 1'b1;
                end else if (tmo_q == TMO_LAST) begin
                    state_d   = FAULT;
                    req_d     = 1'b0;
                    fault_d   = 1'b1;
                    timeout_d = 1'b1;
                    stall_d   = 1'b1;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            FAULT: begin
                stall_d = 1'b1;
                req_d   = 1'b0;
                fault_d = 1'b1;
                if (clear_i) begin
                    state_d     = IDLE;
                    stall_d     = 1'b0;
                    fault_d     = 1'b0;
                    timeout_d   = 1'b0;
                    cnt_clr_all = 1'b1;
                end
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            stall_q   <= 1'b0;
            req_q     <= 1'b0;
            fault_q   <= 1'b0;
            timeout_q <= 1'b0;
            sel_q     <= 2'd0;
            tmo_q     <= '0;
        end else begin
            state_q   <= state_d;
            stall_q   <= stall_d;
            req_q     <= req_d;
            fault_q   <= fault_d;
            timeout_q <= timeout_d;
            sel_q     <= sel_d;
            tmo_q     <= tmo_d;
        end
    end

`ifdef CV32E40P_TMR_THRESHOLD_EN
    localparam logic [CNT_WIDTH-1:0] THRESH  = CNT_WIDTH'(THRESHOLD);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

    logic [2:0][CNT_WIDTH-1:0] cnt_q;
    logic [CNT_WIDTH-1:0]      cnt_cur;
    logic [CNT_WIDTH-1:0]      cnt_inc;

    always_comb begin
        case (err_idx)
            2'd1:    cnt_cur = cnt_q[1];
            2'd2:    cnt_cur = cnt_q[2];
            default: cnt_cur = cnt_q[0];
        endcase
        cnt_inc = (cnt_cur == CNT_MAX) ? CNT_MAX : cnt_cur + 1'b1;
        thr_hit = (cnt_inc >= THRESH);
    end

    // NOTE: the counters are few and visible on ports, so they take the async reset like any state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (cnt_clr_all || (cnt_clr_sel && (2'(i) == sel_q))) begin
                    cnt_q[i] <= '0;
                end else if (cnt_inc_en && (2'(i) == err_idx)) begin
                    cnt_q[i] <= cnt_inc;
                end
            end
        end
    end

    assign err_cnt_a_o = cnt_q[0];
    assign err_cnt_b_o = cnt_q[1];
    assign err_cnt_c_o = cnt_q[2];
`else
    // Without counters the first single-replica error triggers recovery.
    logic unused_cnt_strobes;

    assign thr_hit            = 1'b1;
    assign unused_cnt_strobes = cnt_inc_en ^ cnt_clr_all ^ cnt_clr_sel;
    assign err_cnt_a_o        = '0;
    assign err_cnt_b_o        = '0;
    assign err_cnt_c_o        = '0;
`endif

    assign stall_o      = stall_q;
    assign resync_req_o = req_q;
    assign resync_sel_o = sel_q;
    assign fault_o      = fault_q;
    assign timeout_o    = timeout_q;

endmodule

// File: doc/cv32e40p_tmr_recovery_ctrl.md
CV32E40P_TMR_RECOVERY_CTRL -- requirements
Module: cv32e40p_tmr_recovery_ctrl

Interface
REQ-001 SHALL have parameter CNT_WIDTH, default 8, width of each per-replica error counter.
REQ-002 SHALL have parameter THRESHOLD, default 3, counter value that triggers recovery of a replica (1..2^CNT_WIDTH-1).
REQ-003 SHALL have parameter RESYNC_TIMEOUT, default 16, cycles allowed for resync acknowledge (>=1).
REQ-004 SHALL have one clock and an asynchronous active-low reset: clk input 1 (sole clock, rising edge); rst_n input 1 (async, active-low).
REQ-005 SHALL have valid_i input 1: voter comparison result is meaningful this cycle.
REQ-006 SHALL have err_a_i, err_b_i, err_c_i input 1 each: per-replica mismatch flags from the majority voter.
REQ-007 SHALL have stall_o output 1: hold the TMR pipeline.
REQ-008 SHALL have resync_req_o output 1: request resynchronisation of the replica given by resync_sel_o.
REQ-009 SHALL have resync_sel_o output 2: 0=A, 1=B, 2=C, 3 unused.
REQ-010 SHALL have resync_ack_i input 1: resync complete.
REQ-011 SHALL have clear_i input 1: clear counters and exit FAULT.
REQ-012 SHALL have fault_o output 1: uncorrectable fault, sticky.
REQ-013 SHALL have timeout_o output 1: FAULT was entered through resync timeout.
REQ-014 SHALL have err_cnt_a_o, err_cnt_b_o, err_cnt_c_o output CNT_WIDTH each: per-replica error counts.

Function
REQ-015 SHALL implement FSM states IDLE, STALL, RESYNC, FAULT; all outputs registered.
REQ-016 In IDLE with valid_i=1 and exactly one err flag set, SHALL increment that replica's counter, saturating at 2^CNT_WIDTH-1.
REQ-017 In IDLE, if the incremented count equals or exceeds THRESHOLD, SHALL latch the replica into resync_sel_o and go to STALL; stall_o=1 on the next cycle.
REQ-018 In IDLE with valid_i=1 and two or three err flags set, SHALL go to FAULT with no counter change.
REQ-019 SHALL ignore err flags when valid_i=0 or when the state is not IDLE.
REQ-020 STALL SHALL last exactly one cycle (pipeline drain) and then go to RESYNC.
REQ-021 In RESYNC, resync_req_o SHALL be 1 and stall_o SHALL be 1 until resync_ack_i is sampled high.
REQ-022 On ack, the next cycle SHALL clear the selected counter, deassert resync_req_o and stall_o, and return to IDLE.
REQ-023 In RESYNC, a cycle counter SHALL start at 0 on entry; after RESYNC_TIMEOUT cycles without ack, SHALL go to FAULT with timeout_o=1.
REQ-024 If ack and timeout expiry occur in the same cycle, ack SHALL win.
REQ-025 In FAULT, fault_o=1 and stall_o=1 SHALL hold and resync_req_o=0; only clear_i exits, to IDLE, clearing all counters, fault_o and timeout_o.
REQ-026 In IDLE, clear_i SHALL clear all counters; if an error occurs in the same cycle, clear wins and the error is dropped.
REQ-027 clear_i SHALL be ignored in STALL and RESYNC, and resync_ack_i SHALL be ignored outside RESYNC.
REQ-028 Latency: error at cycle n reaching THRESHOLD -> stall_o=1 at n+1 and resync_req_o=1 at n+2.

Reset
REQ-029 When rst_n=0, SHALL asynchronously force IDLE, all counters 0, resync_sel_o=0, and stall_o, resync_req_o, fault_o, timeout_o all 0.
REQ-030 Reset asserted mid-RESYNC or in FAULT SHALL abandon the operation with no residual state.

Configuration
REQ-031 Macro CV32E40P_TMR_THRESHOLD_EN defined: counting and THRESHOLD behaviour exactly as in REQ-016..REQ-017.
REQ-032 Macro not defined: counters are not implemented, err_cnt_*_o are tied to 0, and the first single-replica error goes directly to STALL (effective THRESHOLD=1).

Verification
REQ-033 With macro on and THRESHOLD=3: err_b_i pulsed 3 times with valid_i=1 -> err_cnt_b_o goes 1,2,3; stall_o=1 next cycle; resync_req_o=1 with resync_sel_o=1 one cycle later.
REQ-034 In RESYNC, ack after 5 cycles -> next cycle err_cnt_b_o=0, stall_o=0, resync_req_o=0, state IDLE.
REQ-035 With RESYNC_TIMEOUT=16 and no ack -> after 16 cycles fault_o=1, timeout_o=1, stall_o=1; clear_i -> all 0.
REQ-036 err_a_i, err_b_i and err_c_i all 1 with valid_i=1 -> fault_o=1 next cycle, counters unchanged.
REQ-037 err_c_i=1 with valid_i=0, and clear_i coincident with err_a_i in IDLE -> no counter change and counters 0; ack coincident with timeout -> IDLE, fault_o=0.
REQ-038 rst_n pulsed low mid-RESYNC -> immediately all outputs 0 and counters 0; macro off: single err_a_i -> stall_o=1 at n+1, err_cnt_a_o stays 0.
